// File: rtl/trap_controller.sv
// trap_controller
//
// Sequences the CSR file for trap entry (exception or external interrupt) and
// mret return. It also arbitrates the CSR file's single write port between
// pipeline CSR instructions and its own trap/return writes.
//
// Ports:
//   clock, reset           - rising-edge clock, asynchronous active-low reset
//   interrupt              - level external interrupt request (gated by MIE)
//   exception              - pipeline exception strobe
//   exceptionCause, trapPC - mcause value and PC captured at trap entry
//   mret                   - mret instruction strobe
//   cpuCsr*                - pipeline CSR write request and read index
//   cpuCsrGrant            - pipeline write accepted this cycle
//   csrReadData            - read data from the CSR file
//   readCSR                - CSR file read index
//   destinationCSR, csrWriteData, csrDestinationEnable - CSR file write port
//   stall                  - hold the pipeline while a sequence runs
//   redirect, redirectPC   - one-cycle PC redirect to trap vector / mepc
module trap_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic        interrupt,
    input  logic        exception,
    input  logic [31:0] exceptionCause,
    input  logic [31:0] trapPC,
    input  logic        mret,
    input  logic        cpuCsrWriteEnable,
    input  logic [3:0]  cpuCsrAddress,
    input  logic [31:0] cpuCsrWriteData,
    input  logic [3:0]  cpuCsrReadAddress,
    output logic        cpuCsrGrant,
    input  logic [31:0] csrReadData,
    output logic [3:0]  readCSR,
    output logic [3:0]  destinationCSR,
    output logic [31:0] csrWriteData,
    output logic        csrDestinationEnable,
    output logic        stall,
    output logic        redirect,
    output logic [31:0] redirectPC
);

    localparam logic [3:0]  MSTATUS_IDX = 4'h0;
    localparam logic [3:0]  MEPC_IDX    = 4'h1;
    localparam logic [3:0]  MCAUSE_IDX  = 4'h2;
    localparam logic [3:0]  MTVEC_IDX   = 4'h8;
    localparam logic [31:0] INT_CAUSE   = 32'h8000000B;

    typedef enum logic [2:0] {
        StIdle,
        StSaveEpc,
        StSaveCause,
        StSaveStatus,
        StVector,
        StReturn
    } state_t;

    state_t      state_q;
    logic        mie_q;
    logic        mpie_q;
    logic [31:0] epc_q;
    logic [31:0] cause_q;

    logic take_trap;
    logic take_mret;
    logic ev;

    // Events are only considered in IDLE; elsewhere the stalled pipeline
    // re-presents them. An interrupt with MIE clear is simply not seen.
    always_comb begin
        take_trap = (state_q == StIdle) && (exception || (interrupt && mie_q));
        take_mret = (state_q == StIdle) && !take_trap && mret;
        ev        = take_trap || take_mret;
    end

    always_comb begin
        cpuCsrGrant          = 1'b0;
        readCSR              = cpuCsrReadAddress;
        destinationCSR       = 4'h0;
        csrWriteData         = 32'h0;
        csrDestinationEnable = 1'b0;
        redirect             = 1'b0;
        redirectPC           = 32'h0;
        stall                = (state_q != StIdle) || ev;

        unique case (state_q)
            StIdle: begin
                // The pipeline owns the write port only when no event fires.
                if (!ev && cpuCsrWriteEnable) begin
                    cpuCsrGrant          = 1'b1;
                    destinationCSR       = cpuCsrAddress;
                    csrWriteData         = cpuCsrWriteData;
                    csrDestinationEnable = 1'b1;
                end
            end
            StSaveEpc: begin
                destinationCSR       = MEPC_IDX;
                csrWriteData         = epc_q;
                csrDestinationEnable = 1'b1;
            end
            StSaveCause: begin
                destinationCSR       = MCAUSE_IDX;
                csrWriteData         = cause_q;
                csrDestinationEnable = 1'b1;
            end
            StSaveStatus: begin
                // MPIE <- MIE, MIE <- 0
                destinationCSR       = MSTATUS_IDX;
                csrWriteData         = {24'b0, mie_q, 3'b0, 1'b0, 3'b0};
                csrDestinationEnable = 1'b1;
            end
            StVector: begin
                readCSR    = MTVEC_IDX;
                redirect   = 1'b1;
                redirectPC = csrReadData & ~32'h3;
            end
            StReturn: begin
                // MIE <- MPIE, MPIE <- 1
                readCSR              = MEPC_IDX;
                redirect             = 1'b1;
                redirectPC           = csrReadData;
                destinationCSR       = MSTATUS_IDX;
                csrWriteData         = {24'b0, 1'b1, 3'b0, mpie_q, 3'b0};
                csrDestinationEnable = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            mie_q   <= 1'b0;
            mpie_q  <= 1'b0;
            epc_q   <= 32'h0;
            cause_q <= 32'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (take_trap) begin
                        epc_q   <= trapPC;
                        cause_q <= exception ? exceptionCause : INT_CAUSE;
                        state_q <= StSaveEpc;
                    end else if (take_mret) begin
                        state_q <= StReturn;
                    end else if (cpuCsrWriteEnable && (cpuCsrAddress == MSTATUS_IDX)) begin
                        // Granted pipeline write to mstatus updates the shadows.
                        mie_q  <= cpuCsrWriteData[3];
                        mpie_q <= cpuCsrWriteData[7];
                    end
                end
                StSaveEpc:   state_q <= StSaveCause;
                StSaveCause: state_q <= StSaveStatus;
                StSaveStatus: begin
                    mpie_q  <= mie_q;
                    mie_q   <= 1'b0;
                    state_q <= StVector;
                end
                StVector: state_q <= StIdle;
                StReturn: begin
                    mie_q   <= mpie_q;
                    mpie_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/trap_controller.md
# trap_controller

Sequences the 16-entry CSR file for trap entry, interrupt entry and `mret` return, and arbitrates the CSR file's single write port between the pipeline's CSR instructions and its own trap sequence. It sits beside the CSR file in `CPU/Control`:
- drives the file's write port (`destinationCSR`, `csrWriteData`, `csrDestinationEnable`) and read index (`readCSR`);
- stalls the pipeline while a sequence runs;
- issues a PC redirect to the trap vector or to the saved return address.

## Interface
- `MSTATUS_IDX`, 4'h0, CSR index of mstatus (only bit 3 MIE and bit 7 MPIE are implemented)
- `MEPC_IDX`, 4'h1, CSR index of mepc
- `MCAUSE_IDX`, 4'h2, CSR index of mcause
- `MTVEC_IDX`, 4'h8, CSR index of mtvec (reset value 32'h40000100 is held in the CSR file)
- `INT_CAUSE`, 32'h8000000B, mcause value written for the external interrupt
- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `interrupt` in 1: level external interrupt request
- `exception` in 1: pipeline exception strobe
- `exceptionCause` in 32: mcause value for the exception
- `trapPC` in 32: PC saved into mepc
- `mret` in 1: mret instruction strobe
- `cpuCsrWriteEnable` in 1: pipeline CSR write request
- `cpuCsrAddress` in 4: pipeline write index
- `cpuCsrWriteData` in 32: pipeline write data
- `cpuCsrReadAddress` in 4: pipeline read index
- `cpuCsrGrant` out 1: pipeline write accepted this cycle
- `csrReadData` in 32: read data from the CSR file
- `readCSR` out 4: CSR file read index
- `destinationCSR` out 4: CSR file write index
- `csrWriteData` out 32: CSR file write data
- `csrDestinationEnable` out 1: CSR file write enable
- `stall` out 1: hold the pipeline
- `redirect` out 1: one-cycle PC redirect strobe
- `redirectPC` out 32: redirect target

## Operation
- **States:** IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, VECTOR, RETURN.
- **Shadow bits:** `mieS` and `mpieS` are registers, both reset to 0. A granted pipeline write to `MSTATUS_IDX` loads `mieS = data[3]` and `mpieS = data[7]`.
- **Event priority in IDLE:** `exception` > (`interrupt` && `mieS`) > `mret`. An event is `ev`.
- **On trap `ev`:**
  - capture `trapPC` into `epcR`;
  - capture the cause into `causeR` (`exceptionCause`, or `INT_CAUSE` for the interrupt);
  - next state SAVE_EPC.
- **On `mret`:** next state RETURN.
- **SAVE_EPC:** write `MEPC_IDX` ← `epcR`.
- **SAVE_CAUSE:** write `MCAUSE_IDX` ← `causeR`.
- **SAVE_STATUS:**
  - write `MSTATUS_IDX` ← {24'b0, `mieS`, 3'b0, 1'b0, 3'b0};
  - `mpieS` ← `mieS`, `mieS` ← 0.
- **VECTOR:**
  - `readCSR` = `MTVEC_IDX`;
  - `redirect` = 1, `redirectPC` = `csrReadData` & ~32'h3;
  - next state IDLE.
- **RETURN:**
  - `readCSR` = `MEPC_IDX`;
  - `redirect` = 1, `redirectPC` = `csrReadData`;
  - write `MSTATUS_IDX` ← {24'b0, 1'b1, 3'b0, `mpieS`, 3'b0};
  - `mieS` ← `mpieS`, `mpieS` ← 1;
  - next state IDLE.
- **Write-port arbitration:** in IDLE with no `ev`, `cpuCsrGrant` = `cpuCsrWriteEnable`, and the port carries the pipeline request. In all other cases the grant is 0 and the request is dropped; the pipeline is stalled, so it will re-present the request.
- **Read index:** `readCSR` = `cpuCsrReadAddress` in IDLE and in all states other than VECTOR and RETURN.
- **`stall`** = (state != IDLE) || `ev`.
- **`interrupt` while `mieS` = 0:** ignored and not latched; a level still high later is taken once `mieS` = 1.
- **Events outside IDLE:** ignored; the pipeline is stalled and re-presents them.

## Timing
- **Reset:** state IDLE, `mieS` = `mpieS` = 0, `epcR` = `causeR` = 0. Every output is 0 except `readCSR` (= `cpuCsrReadAddress`). Reset asserted mid-sequence aborts immediately, with no redirect and no further writes.
- **State-driven outputs:** write-port and redirect outputs are combinational from the registered state and the captured registers. In IDLE the grant path is combinational from the pipeline inputs.
- **Trap latency:** `ev` at cycle N →
  - N+1 mepc write;
  - N+2 mcause write;
  - N+3 mstatus write;
  - N+4 `redirect`.
  - `stall` is high over N..N+4 and low at N+5.
- **mret latency:** `mret` at cycle N → N+1 mstatus write plus `redirect`; `stall` is high over N..N+1.
- **Back-to-back:** a new event is accepted in the first IDLE cycle after VECTOR or RETURN.

## Test plan
- **Exception entry:** after reset, `exception`=1, `exceptionCause`=2, `trapPC`=32'h100 → CSR writes mepc=32'h100, mcause=2, mstatus=0 on consecutive cycles; `redirect` with `redirectPC`=32'h40000100 four cycles after the strobe.
- **Interrupt gating:** `interrupt`=1 with `mieS`=0 → no sequence, `stall`=0. Then a pipeline write of mstatus=32'h8 → the interrupt is taken; mcause=32'h8000000B; mstatus is written 32'h80.
- **mret:** after the interrupt entry above, `mret` → mstatus written 32'h88; `redirectPC` = saved mepc one cycle later; `mieS`=1.
- **Arbitration:** `cpuCsrWriteEnable` during SAVE_CAUSE → `cpuCsrGrant`=0, and the only write that cycle is mcause. The same request in IDLE with no event → granted the same cycle.
- **Priority:** `exception`, `interrupt` (with `mieS`=1) and `mret` in the same cycle → mcause = `exceptionCause`.
- **Reset mid-sequence:** `reset` low in SAVE_CAUSE → no mstatus write and no redirect; after release the block is IDLE with `stall`=0.
